// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage.
//
// Owns the PC, issues one-word fetches to instruction memory under a credit
// limit, tags returning words with their fetch PC and buffers them for decode.
// A redirect from the branch unit retargets the PC, flushes buffered work and
// arranges for every response still outstanding to be discarded on arrival.
//
// Parameters
//   XLEN       address width
//   RESET_PC   PC loaded on reset (4-byte aligned)
//   BUF_DEPTH  instruction buffer entries (power of 2, >= 2); also the limit
//              on outstanding requests plus buffered words
//
// Ports
//   i_clk, i_rst_n              clock (rising edge), async active-low reset
//   o_imem_req / o_imem_addr    fetch request and its address (current PC)
//   i_imem_gnt                  request accepted this cycle
//   i_imem_rvalid/i_imem_rdata  in-order responses, >= 1 cycle after grant
//   i_redirect / i_redirect_pc  taken branch/jump and its target
//   o_valid / o_instr / o_pc    buffered instruction presented to decode
//   i_ready                     decode accepts (o_valid & i_ready pops)
//   o_fetch_fault               only with COTM32_FETCH_ALIGN_CHECK_EN
//
// Build option COTM32_FETCH_ALIGN_CHECK_EN: a misaligned redirect target stops
// fetching and, once all older responses are discarded, presents a fault
// entry (o_valid=1, o_fetch_fault=1, o_pc=target, o_instr=0) that stays up
// until the next redirect. Without the option, target bits [1:0] are cleared.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    ,
    output logic            o_fetch_fault
`endif
);

    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    // RUN: every response belongs to the current stream.
    // FLUSH: drop_q responses from an abandoned stream are still due.
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;   // all outstanding requests, dropped ones included
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   brd_q, brd_d, bwr_q, bwr_d;   // instruction buffer pointers
    logic [AW-1:0]   qrd_q, qrd_d, qwr_q, qwr_d;   // issued-address queue pointers
    logic            fault_q, fault_d;

    logic [31:0]     buf_instr [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc    [BUF_DEPTH];
    logic [XLEN-1:0] pcq       [BUF_DEPTH];

    logic            grant, push, pop, buf_valid, fault_show;
    logic [XLEN-1:0] tgt;
    logic [CW-1:0]   outstanding;

`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    assign tgt = i_redirect_pc;
`else
    logic unused_tgt_lo;
    assign unused_tgt_lo = ^i_redirect_pc[1:0];
    assign tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
`endif

    assign buf_valid  = (cnt_q != '0);
    assign fault_show = fault_q && (state_q == RUN);

    // Gated by reset directly so that no request is raised while held in reset
    // and the first one appears in the very first cycle after release.
    assign o_imem_req = i_rst_n && !fault_q &&
                        (({1'b0, inflight_q} + {1'b0, cnt_q}) < DEPTH_W);

    assign grant = o_imem_req && i_imem_gnt;
    assign push  = i_imem_rvalid && (state_q == RUN);
    assign pop   = buf_valid && i_ready;

    // Outstanding count after this cycle's grant/response, whatever stream they belong to.
    assign outstanding = inflight_q + CW'(grant) - CW'(i_imem_rvalid);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = outstanding;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        brd_d      = brd_q;
        bwr_d      = bwr_q;
        qrd_d      = qrd_q;
        qwr_d      = qwr_q;
        fault_d    = fault_q;
        if (i_redirect) begin
            // Everything still outstanding, including a same-cycle grant,
            // now belongs to the abandoned stream.
            pc_d   = tgt;
            drop_d = outstanding;
            cnt_d  = '0;
            brd_d  = '0;
            bwr_d  = '0;
            qrd_d  = '0;
            qwr_d  = '0;
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
            fault_d = (i_redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (grant) begin
                pc_d  = pc_q + XLEN'(4);
                qwr_d = qwr_q + AW'(1);
            end
            if (i_imem_rvalid && (state_q == FLUSH))
                drop_d = drop_q - CW'(1);
            if (push) begin
                bwr_d = bwr_q + AW'(1);
                qrd_d = qrd_q + AW'(1);
            end
            if (pop)
                brd_d = brd_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        state_d = (drop_d != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            brd_q      <= '0;
            bwr_q      <= '0;
            qrd_q      <= '0;
            qwr_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            brd_q      <= brd_d;
            bwr_q      <= bwr_d;
            qrd_q      <= qrd_d;
            qwr_q      <= qwr_d;
            fault_q    <= fault_d;
        end
    end

    // Storage needs no reset: the pointers and count qualify every read.
    always_ff @(posedge i_clk) begin
        if (!i_redirect && push) begin
            buf_instr[bwr_q] <= i_imem_rdata;
            buf_pc[bwr_q]    <= pcq[qrd_q];
        end
        if (!i_redirect && grant)
            pcq[qwr_q] <= pc_q;
    end

    assign o_imem_addr = pc_q;
    assign o_valid     = buf_valid || fault_show;
    assign o_instr     = buf_valid ? buf_instr[brd_q] : 32'h0;
    assign o_pc        = buf_valid ? buf_pc[brd_q] : (fault_show ? pc_q : '0);
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
    assign o_fetch_fault = fault_show;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order memory model,
// a scoreboard of expected {pc, instr} pairs filled by the stimulus, and a
// monitor that pops and compares on every decode handshake.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        fault_w;

    fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_ready       (i_ready)
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        ,
        .o_fetch_fault (fault_w)
`endif
    );
`ifndef COTM32_FETCH_ALIGN_CHECK_EN
    assign fault_w = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t pend [$];
    int cyc    = 0;
    int lat    = 1;
    int grants = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        i_redirect = 1'b1;
        i_redirect_pc = tgt;
        tick();
        i_redirect = 1'b0;
    endtask

    task automatic expect_seq(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(first + 32'(4 * k));
    endtask

    task automatic drain(input string name);
        int n = 0;
        i_ready = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d outputs missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        i_ready = 1'b0;
    endtask

    // Memory model: handshakes are sampled on the falling edge, responses
    // are driven 1 time unit after the rising edge once their latency expires.
    initial begin
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) pend.delete();
            else begin
                if (i_imem_rvalid && pend.size() > 0) void'(pend.pop_front());
                if (o_imem_req && i_imem_gnt) begin
                    pend.push_back('{o_imem_addr, cyc + lat});
                    grants++;
                end
            end
            @(posedge i_clk);
            #1;
            cyc++;
            if (i_rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = instr_of(pend[0].a);
            end else begin
                i_imem_rvalid = 1'b0;
                i_imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: every decode handshake must match the head of the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready && !fault_w) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc %h, required no output", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", o_pc, e);
                    chk("pop_instr", o_instr, instr_of(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g0;
        i_rst_n = 1'b0;
        i_imem_gnt = 1'b1;
        i_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        #12;
        chk("rst_req", 32'(o_imem_req), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instr, 32'h0);

        // 1: straight-line fetch from reset
        expect_seq(32'h0, 4);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        #1;
        chk("first_req", 32'(o_imem_req), 32'h1);
        chk("first_addr", o_imem_addr, 32'h0);
        drain("seq");

        // 2: decode stalled -> credit caps grants at buffer depth
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        g0 = grants;
        repeat (10) tick();
        chk("stall_grants", 32'(grants - g0), 32'd2);
        chk("stall_valid", 32'(o_valid), 32'h1);
        chk("stall_addr", o_imem_addr, 32'h8);
        chk("stall_req", 32'(o_imem_req), 32'h0);
        expect_seq(32'h0, 4);
        drain("stall");

        // 3: redirect with two responses outstanding
        lat = 3;
        redirect(32'h80);
        n = 0;
        while (!(pend.size() == 2 && !i_imem_rvalid) && n < 20) begin tick(); n++; end
        chk("two_inflight_req", 32'(o_imem_req), 32'h0);
        redirect(32'h100);
        chk("redir_addr", o_imem_addr, 32'h100);
        chk("redir_valid", 32'(o_valid), 32'h0);
        expect_seq(32'h100, 3);
        drain("redir");

        // 4: redirect with same-cycle grant and response, then again in FLUSH
        lat = 1;
        redirect(32'h180);
        n = 0;
        while (!(o_imem_req && i_imem_rvalid) && n < 20) begin tick(); n++; end
        chk("grant_rvalid_cycle", 32'(o_imem_req && i_imem_rvalid), 32'h1);
        redirect(32'h300);
        redirect(32'h200);
        expect_seq(32'h200, 4);
        drain("double_redir");

        // 5: PC wraps past the top of the address space
        redirect(32'hFFFF_FFF8);
        n = 0;
        while (!(o_imem_req && o_imem_addr == 32'hFFFF_FFFC) && n < 20) begin tick(); n++; end
        tick();
        chk("wrap_addr", o_imem_addr, 32'h0);
        expect_seq(32'hFFFF_FFF8, 4);
        drain("wrap");

        // 6: misaligned redirect target
`ifdef COTM32_FETCH_ALIGN_CHECK_EN
        redirect(32'h102);
        chk("fault_req", 32'(o_imem_req), 32'h0);
        n = 0;
        while (!o_valid && n < 20) begin tick(); n++; end
        chk("fault_flag", 32'(fault_w), 32'h1);
        chk("fault_pc", o_pc, 32'h102);
        chk("fault_instr", o_instr, 32'h0);
        i_ready = 1'b1;
        repeat (3) tick();
        i_ready = 1'b0;
        chk("fault_hold", 32'(fault_w), 32'h1);
        redirect(32'h500);
        chk("fault_clear", 32'(fault_w), 32'h0);
        expect_seq(32'h500, 2);
        drain("after_fault");
`else
        redirect(32'h102);
        chk("align_addr", o_imem_addr, 32'h100);
        expect_seq(32'h100, 2);
        drain("align");
`endif

        // Async reset in the middle of a flush
        lat = 3;
        redirect(32'h600);
        n = 0;
        while (pend.size() != 2 && n < 20) begin tick(); n++; end
        redirect(32'h700);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("async_req", 32'(o_imem_req), 32'h0);
        chk("async_valid", 32'(o_valid), 32'h0);
        chk("async_pc", o_pc, 32'h0);
        chk("async_instr", o_instr, 32'h0);
        chk("async_addr", o_imem_addr, 32'h0);
        chk("async_fault", 32'(fault_w), 32'h0);
        tick();
        i_rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
